// File: rtl/ev21g1_pkg.sv
// ev21g1_pkg: shared defaults and the fetch FSM state type for the ev21g1
// instruction fetch stage.
//   DEF_ADDR_W   : program counter / program memory address width (words)
//   DEF_INSTR_W  : instruction width
//   DEF_RESET_PC : PC value loaded by reset
package ev21g1_pkg;

    localparam int unsigned DEF_ADDR_W   = 10;
    localparam int unsigned DEF_INSTR_W  = 32;
    localparam int unsigned DEF_RESET_PC = 0;

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/ev21g1_fetch_buf.sv
// ev21g1_fetch_buf: 2-entry in-order FIFO of {pc, instr} between fetch and decode.
// Entry 0 is always the head, so the head outputs come straight from a register
// and stay stable while no pop happens.
//   clk, reset     : clock, synchronous active-high reset (clears data too)
//   i_flush        : synchronous flush, wins over push and pop
//   i_push         : write {i_push_pc, i_push_instr} behind the live entries
//   i_pop          : drop the head (ignored when empty)
//   o_count        : occupancy 0..2
//   o_valid        : head holds an entry
//   o_head_pc      : head pc
//   o_head_instr   : head instruction
import ev21g1_pkg::*;

module ev21g1_fetch_buf #(
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned INSTR_W = DEF_INSTR_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_flush,
    input  logic               i_push,
    input  logic [ADDR_W-1:0]  i_push_pc,
    input  logic [INSTR_W-1:0] i_push_instr,
    input  logic               i_pop,
    output logic [1:0]         o_count,
    output logic               o_valid,
    output logic [ADDR_W-1:0]  o_head_pc,
    output logic [INSTR_W-1:0] o_head_instr
);

    logic [ADDR_W-1:0]  r_pc    [2];
    logic [INSTR_W-1:0] r_instr [2];
    logic [1:0]         r_count;
    logic               w_pop;

    assign w_pop = i_pop & (r_count != 2'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count    <= '0;
            r_pc[0]    <= '0;
            r_pc[1]    <= '0;
            r_instr[0] <= '0;
            r_instr[1] <= '0;
        end else if (i_flush) begin
            r_count <= '0;
        end else begin
            case ({i_push, w_pop})
                2'b11: begin
                    // Simultaneous pop and push: the new word lands right
                    // behind whatever survives the pop.
                    if (r_count == 2'd1) begin
                        r_pc[0]    <= i_push_pc;
                        r_instr[0] <= i_push_instr;
                    end else begin
                        r_pc[0]    <= r_pc[1];
                        r_instr[0] <= r_instr[1];
                        r_pc[1]    <= i_push_pc;
                        r_instr[1] <= i_push_instr;
                    end
                end
                2'b01: begin
                    r_pc[0]    <= r_pc[1];
                    r_instr[0] <= r_instr[1];
                    r_count    <= r_count - 2'd1;
                end
                2'b10: begin
                    if (r_count == 2'd0) begin
                        r_pc[0]    <= i_push_pc;
                        r_instr[0] <= i_push_instr;
                    end else begin
                        r_pc[1]    <= i_push_pc;
                        r_instr[1] <= i_push_instr;
                    end
                    r_count <= r_count + 2'd1;
                end
                default: ;
            endcase
        end
    end

    assign o_count      = r_count;
    assign o_valid      = (r_count != 2'd0);
    assign o_head_pc    = r_pc[0];
    assign o_head_instr = r_instr[0];

endmodule

// File: rtl/ev21g1_fetch_unit.sv
// ev21g1_fetch_unit: instruction fetch stage. Owns the PC, drives a 1-cycle
// latency synchronous program memory, buffers fetched words in a 2-entry FIFO
// and hands them to decode over valid/ready.
//   clk, reset        : clock, synchronous active-high reset
//   prog_addr/prog_en : memory request (sampled by memory at the rising edge)
//   prog_data         : memory read data, valid the cycle after the request
//   instr_valid/instr/instr_pc : buffer head to decode
//   instr_ready       : decode accepts the head this cycle
//   redirect_en/redirect_pc : taken branch/jump, flush and refetch
//   halt_req          : stop issuing new fetches
import ev21g1_pkg::*;

module ev21g1_fetch_unit #(
    parameter int unsigned       ADDR_W   = DEF_ADDR_W,
    parameter int unsigned       INSTR_W  = DEF_INSTR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC)
) (
    input  logic               clk,
    input  logic               reset,
    output logic [ADDR_W-1:0]  prog_addr,
    output logic               prog_en,
    input  logic [INSTR_W-1:0] prog_data,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    input  logic               instr_ready,
    input  logic               redirect_en,
    input  logic [ADDR_W-1:0]  redirect_pc,
    input  logic               halt_req
);

    fetch_state_t      r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_inflight_pc;
    logic              r_inflight;
    logic [1:0]        w_count;
    logic [2:0]        w_occ;
    logic              w_pop;
    logic              w_issue;

    assign w_pop = instr_valid & instr_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        prog_en     = 1'b0;
        prog_addr   = r_pc;
        // Occupancy the buffer will have after this edge if nothing new is issued;
        // a pop implies count >= 1, so this never underflows.
        w_occ = {1'b0, w_count} - {2'b00, w_pop} + {2'b00, r_inflight};
        if (redirect_en) begin
            prog_addr   = redirect_pc;
            prog_en     = 1'b1;
            w_state_nxt = ST_RUN;
        end else begin
            w_issue = (r_state != ST_HALTED) && !halt_req && (w_occ < 3'd2);
            prog_en = w_issue;
            case (r_state)
                ST_BOOT:   w_state_nxt = ST_RUN;
                ST_RUN:    if (halt_req) w_state_nxt = ST_HALTED;
                ST_HALTED: w_state_nxt = ST_HALTED;
                default:   w_state_nxt = ST_BOOT;
            endcase
        end
        if (reset) prog_en = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_BOOT;
            r_pc          <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (redirect_en) begin
                r_pc          <= redirect_pc + ADDR_W'(1);
                r_inflight    <= 1'b1;
                r_inflight_pc <= redirect_pc;
            end else begin
                r_inflight <= w_issue;
                if (w_issue) begin
                    r_pc          <= r_pc + ADDR_W'(1);
                    r_inflight_pc <= r_pc;
                end
            end
        end
    end

    // Redirect flushes the buffer and, since flush beats push, also drops the
    // word returning from the old in-flight fetch.
    ev21g1_fetch_buf #(
        .ADDR_W  (ADDR_W),
        .INSTR_W (INSTR_W)
    ) u_buf (
        .clk          (clk),
        .reset        (reset),
        .i_flush      (redirect_en),
        .i_push       (r_inflight),
        .i_push_pc    (r_inflight_pc),
        .i_push_instr (prog_data),
        .i_pop        (w_pop),
        .o_count      (w_count),
        .o_valid      (instr_valid),
        .o_head_pc    (instr_pc),
        .o_head_instr (instr)
    );

endmodule

// File: tb/tb_ev21g1_fetch_unit.sv
module tb_ev21g1_fetch_unit;

    logic        clk;
    logic        reset, reset2;
    logic        instr_ready;
    logic        redirect_en;
    logic [9:0]  redirect_pc;
    logic        halt_req;
    logic        zero_bit;
    logic [9:0]  zero_pc;
    logic        one_bit;

    logic [9:0]  prog_addr, prog_addr2;
    logic        prog_en, prog_en2;
    logic [31:0] prog_data, prog_data2;
    logic        instr_valid, instr_valid2;
    logic [31:0] instr, instr2;
    logic [9:0]  instr_pc, instr_pc2;

    logic [9:0]  r_maddr, r_maddr2;

    int n_checks = 0;
    int n_errors = 0;

    ev21g1_fetch_unit #(.ADDR_W(10), .INSTR_W(32), .RESET_PC(10'h000)) dut (
        .clk         (clk),
        .reset       (reset),
        .prog_addr   (prog_addr),
        .prog_en     (prog_en),
        .prog_data   (prog_data),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_ready (instr_ready),
        .redirect_en (redirect_en),
        .redirect_pc (redirect_pc),
        .halt_req    (halt_req)
    );

    ev21g1_fetch_unit #(.ADDR_W(10), .INSTR_W(32), .RESET_PC(10'h3FE)) dut_wrap (
        .clk         (clk),
        .reset       (reset2),
        .prog_addr   (prog_addr2),
        .prog_en     (prog_en2),
        .prog_data   (prog_data2),
        .instr_valid (instr_valid2),
        .instr       (instr2),
        .instr_pc    (instr_pc2),
        .instr_ready (one_bit),
        .redirect_en (zero_bit),
        .redirect_pc (zero_pc),
        .halt_req    (zero_bit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Program memory models: data = 0xA0000000 | last sampled address.
    initial begin
        r_maddr  = '0;
        r_maddr2 = '0;
    end
    always @(posedge clk) begin
        if (prog_en)  r_maddr  <= prog_addr;
        if (prog_en2) r_maddr2 <= prog_addr2;
    end
    assign prog_data  = 32'hA000_0000 | {22'd0, r_maddr};
    assign prog_data2 = 32'hA000_0000 | {22'd0, r_maddr2};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk_head(input string tag, input logic [9:0] pc);
        check_eq({tag, "_valid"}, {31'd0, instr_valid}, 32'd1);
        check_eq({tag, "_pc"}, {22'd0, instr_pc}, {22'd0, pc});
        check_eq({tag, "_instr"}, instr, 32'hA000_0000 | {22'd0, pc});
    endtask

    task automatic chk_head2(input string tag, input logic [9:0] pc);
        check_eq({tag, "_valid"}, {31'd0, instr_valid2}, 32'd1);
        check_eq({tag, "_pc"}, {22'd0, instr_pc2}, {22'd0, pc});
        check_eq({tag, "_instr"}, instr2, 32'hA000_0000 | {22'd0, pc});
    endtask

    initial begin
        reset       = 1'b1;
        reset2      = 1'b1;
        instr_ready = 1'b1;
        redirect_en = 1'b0;
        redirect_pc = '0;
        halt_req    = 1'b0;
        zero_bit    = 1'b0;
        zero_pc     = '0;
        one_bit     = 1'b1;

        repeat (3) tick();
        check_eq("rst_valid", {31'd0, instr_valid}, 32'd0);
        check_eq("rst_instr", instr, 32'd0);
        check_eq("rst_pc", {22'd0, instr_pc}, 32'd0);
        check_eq("rst_en", {31'd0, prog_en}, 32'd0);
        check_eq("rst_addr", {22'd0, prog_addr}, 32'd0);
        check_eq("rst_addr2", {22'd0, prog_addr2}, 32'h3FE);

        // Release: BOOT issues RESET_PC in the first cycle.
        reset  = 1'b0;
        reset2 = 1'b0;
        #1;
        check_eq("boot_en", {31'd0, prog_en}, 32'd1);
        check_eq("boot_addr", {22'd0, prog_addr}, 32'd0);
        tick();
        check_eq("lat1_valid", {31'd0, instr_valid}, 32'd0);
        check_eq("lat1_valid2", {31'd0, instr_valid2}, 32'd0);
        tick(); chk_head("seq0", 10'd0); chk_head2("wrap0", 10'h3FE);
        tick(); chk_head("seq1", 10'd1); chk_head2("wrap1", 10'h3FF);
        tick(); chk_head("seq2", 10'd2); chk_head2("wrap2", 10'h000);
        tick(); chk_head("seq3", 10'd3); chk_head2("wrap3", 10'h001);
        tick(); chk_head("seq4", 10'd4);

        // Decode stall at pc 4.
        instr_ready = 1'b0;
        #1;
        check_eq("stall_en0", {31'd0, prog_en}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_head("stall", 10'd4);
            check_eq("stall_en", {31'd0, prog_en}, 32'd0);
        end
        instr_ready = 1'b1;
        #1;
        check_eq("resume_en", {31'd0, prog_en}, 32'd1);
        check_eq("resume_addr", {22'd0, prog_addr}, 32'd6);
        tick(); chk_head("res5", 10'd5);
        tick(); chk_head("res6", 10'd6);
        tick(); chk_head("res7", 10'd7);

        // Redirect with one buffered word and one in flight.
        instr_ready = 1'b0;
        redirect_en = 1'b1;
        redirect_pc = 10'h100;
        #1;
        check_eq("redir_en", {31'd0, prog_en}, 32'd1);
        check_eq("redir_addr", {22'd0, prog_addr}, 32'h100);
        tick();
        redirect_en = 1'b0;
        instr_ready = 1'b1;
        check_eq("redir_gap", {31'd0, instr_valid}, 32'd0);
        tick(); chk_head("tgt0", 10'h100);
        tick(); chk_head("tgt1", 10'h101);
        tick(); chk_head("tgt2", 10'h102);

        // Halt: drain in-flight word, then idle.
        halt_req = 1'b1;
        #1;
        check_eq("halt_en", {31'd0, prog_en}, 32'd0);
        tick(); chk_head("drain", 10'h103);
        tick();
        check_eq("halted_valid", {31'd0, instr_valid}, 32'd0);
        check_eq("halted_en", {31'd0, prog_en}, 32'd0);
        halt_req = 1'b0;
        #1;
        check_eq("halted_stays", {31'd0, prog_en}, 32'd0);
        tick();
        check_eq("halted_valid2", {31'd0, instr_valid}, 32'd0);
        redirect_en = 1'b1;
        redirect_pc = 10'h020;
        #1;
        check_eq("wake_en", {31'd0, prog_en}, 32'd1);
        check_eq("wake_addr", {22'd0, prog_addr}, 32'h20);
        tick();
        redirect_en = 1'b0;
        check_eq("wake_gap", {31'd0, instr_valid}, 32'd0);
        tick(); chk_head("wake0", 10'h020);
        tick(); chk_head("wake1", 10'h021);

        // Fill buffer to two, then reset mid-operation.
        instr_ready = 1'b0;
        tick(); chk_head("full", 10'h021);
        check_eq("full_en", {31'd0, prog_en}, 32'd0);
        reset = 1'b1;
        #1;
        check_eq("mrst_en", {31'd0, prog_en}, 32'd0);
        tick();
        check_eq("mrst_valid", {31'd0, instr_valid}, 32'd0);
        check_eq("mrst_instr", instr, 32'd0);
        check_eq("mrst_pc", {22'd0, instr_pc}, 32'd0);
        check_eq("mrst_addr", {22'd0, prog_addr}, 32'd0);
        reset       = 1'b0;
        instr_ready = 1'b1;
        tick();
        check_eq("rerun_gap", {31'd0, instr_valid}, 32'd0);
        tick(); chk_head("rerun0", 10'd0);
        tick(); chk_head("rerun1", 10'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
